multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle main control FSM for the RISC core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the 3-bit `alu_op` consumed by the ALU control decoder. It also generates the PC, IR, register-file and memory strobes, stalls on a memory ready handshake, and counts retired instructions. It sits between the instruction register / memory interface and the datapath.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; asynchronous, active-low
- `start`  in  1  level; leaves IDLE when high
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `zero`  in  1  ALU zero flag; sampled in EXEC
- `mem_ready`  in  1  memory completes the current access this cycle
- `alu_op`  out  3  to ALU control decoder
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  datapath strobes
- `alu_src_imm`  out  1  ALU B operand selects immediate
- `mem_to_reg`  out  1  write-back selects memory data
- `illegal`  out  1  one-cycle pulse on an unknown opcode
- `halted`  out  1  high in HALT
- `retired`  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State encoding lives in the package.
- Opcode classes (latched into `cls_q` in DECODE): 000000 ARITH, 000001 LOGIC, 000010 SHIFT, 000011 LOAD, 000100 STORE, 000101 BEQ, 000110 JUMP, 111111 HALT. Every other value is ILLEGAL.
- `alu_op` by state and class:
  - EXEC ARITH = 001, LOGIC = 010, SHIFT = 011, LOAD/STORE = 110 (add), BEQ = 111 (sub).
  - FETCH = 110 (PC+4).
  - All other states = 000.
- Transitions:
  - IDLE→FETCH when `start`.
  - FETCH holds until `mem_ready`, then →DECODE.
  - DECODE: JUMP→FETCH; HALT→HALT; ILLEGAL→FETCH; else →EXEC.
  - EXEC: ARITH/LOGIC/SHIFT→WB; LOAD/STORE→MEM; BEQ→FETCH.
  - MEM holds until `mem_ready`. LOAD→WB; STORE→FETCH.
  - WB→FETCH.
  - HALT is sticky until `rst_n` low.
- Strobes (Moore; functions of state and `cls_q` except where noted):
  - FETCH: `mem_read`=1. `ir_write` and `pc_write` are high only in the cycle that `mem_ready`=1.
  - DECODE/JUMP: `pc_write`=1.
  - EXEC: `alu_src_imm`=1 for LOAD/STORE/SHIFT. For BEQ, `pc_write`=`zero`.
  - MEM: `mem_read` for LOAD, `mem_write` for STORE. Both stay held while stalled.
  - WB: `reg_write`=1. `mem_to_reg`=1 for LOAD.
  - DECODE/ILLEGAL: `illegal`=1 for that cycle.
- `retired` increments by 1 on the final cycle of every legal instruction: WB, STORE MEM with `mem_ready`, BEQ EXEC, and JUMP DECODE. It wraps modulo 2^CNT_W. ILLEGAL and HALT do not count.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `cls_q`=0, `retired`=0.
  - Every strobe, `alu_op`=000, `illegal`=0, `halted`=0.
- Reset mid-instruction aborts immediately. No strobe is asserted after `rst_n` falls.
- Cycle counts with zero-wait memory:
  - ARITH/LOGIC/SHIFT = 4 (F,D,E,W).
  - LOAD = 5.
  - STORE = 4.
  - BEQ = 3.
  - JUMP = 2.
- Each `mem_ready`-low cycle adds one cycle to FETCH or MEM.
- `mem_ready` outside FETCH/MEM is ignored.
- `start` is ignored outside IDLE.
- `opcode` is sampled only in DECODE; changes elsewhere have no effect.

## Structure
- Package `ctrl_pkg`: state enum, opcode class constants (6-bit), `alu_op` constants (ALU_ARITH=001, ALU_LOGIC=010, ALU_SHIFT=011, ALU_ADD=110, ALU_SUB=111, ALU_NONE=000).
- Sub-module `opcode_classifier`: combinational 6-bit opcode → class. The FSM, strobe decode and counter stay in `multicycle_ctrl`.

## Test plan
- Reset then `start`=1, `mem_ready`=1, opcode 000000 → state sequence F,D,E,W. `alu_op`=001 in E. `reg_write` only in W. `retired`=1 after 4 cycles.
- LOAD (000011), `mem_ready` low for 2 cycles in MEM → MEM lasts 3 cycles with `mem_read` held and `alu_op`=110 in E. `mem_to_reg`=`reg_write`=1 in W. Total 7 cycles.
- BEQ (000101) with `zero`=1, then with `zero`=0 → `alu_op`=111 and `pc_write`=1 / 0 in E. Each takes 3 cycles and `retired` increments each time.
- Opcode 101010 → `illegal` pulses one cycle in D, next state FETCH, `retired` unchanged. Then opcode 111111 → `halted`=1 permanently, `start` ignored.
- Preload `retired` to 0xFFFF via a run of 65535 JUMPs, one more JUMP → wraps to 0x0000.
- Assert `rst_n` low in the middle of a STORE MEM stall → all outputs 0 asynchronously. After release the block is in IDLE and waits for `start`.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle main control unit.
// States, opcode classes, raw opcodes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ARITH   = 3'd0,
        C_LOGIC   = 3'd1,
        C_SHIFT   = 3'd2,
        C_LOAD    = 3'd3,
        C_STORE   = 3'd4,
        C_BEQ     = 3'd5,
        C_JUMP    = 3'd6,
        C_ILLEGAL = 3'd7
    } cls_t;

    // HALT has its own class slot folded into the decode path below
    localparam logic [5:0] OP_ARITH = 6'b000000;
    localparam logic [5:0] OP_LOGIC = 6'b000001;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_LOAD  = 6'b000011;
    localparam logic [5:0] OP_STORE = 6'b000100;
    localparam logic [5:0] OP_BEQ   = 6'b000101;
    localparam logic [5:0] OP_JUMP  = 6'b000110;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_NONE  = 3'b000;
    localparam logic [2:0] ALU_ARITH = 3'b001;
    localparam logic [2:0] ALU_LOGIC = 3'b010;
    localparam logic [2:0] ALU_SHIFT = 3'b011;
    localparam logic [2:0] ALU_ADD   = 3'b110;
    localparam logic [2:0] ALU_SUB   = 3'b111;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-class decode for the main control FSM.
// HALT is reported separately since it never reaches EXEC.
module opcode_classifier
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output cls_t       cls,
    output logic       is_halt
);

    always_comb begin
        cls     = C_ILLEGAL;
        is_halt = 1'b0;
        case (opcode)
            OP_ARITH: cls = C_ARITH;
            OP_LOGIC: cls = C_LOGIC;
            OP_SHIFT: cls = C_SHIFT;
            OP_LOAD:  cls = C_LOAD;
            OP_STORE: cls = C_STORE;
            OP_BEQ:   cls = C_BEQ;
            OP_JUMP:  cls = C_JUMP;
            OP_HALT:  is_halt = 1'b1;
            default:  cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control: sequences F/D/E/M/W, drives datapath
// strobes and alu_op, stalls on mem_ready, counts retired instructions.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       alu_op,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_imm,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    cls_t   dec_cls;
    logic   dec_halt;
    logic   retire;
    logic [CNT_W-1:0] retired_q;

    opcode_classifier u_cls (
        .opcode  (opcode),
        .cls     (dec_cls),
        .is_halt (dec_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ARITH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (retire) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign retired = retired_q;
    assign halted  = (state_q == S_HALT);

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        alu_op      = ALU_NONE;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                alu_op   = ALU_ADD;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                // Opcode is live here; later states rely on cls_q only
                if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_cls == C_JUMP) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (dec_cls == C_ILLEGAL) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_ARITH: begin
                        alu_op  = ALU_ARITH;
                        state_d = S_WB;
                    end
                    C_LOGIC: begin
                        alu_op  = ALU_LOGIC;
                        state_d = S_WB;
                    end
                    C_SHIFT: begin
                        alu_op      = ALU_SHIFT;
                        alu_src_imm = 1'b1;
                        state_d     = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_write = zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LOAD);
                mem_write = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LOAD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;

    localparam int CNT_W = 8;

    // {alu_op, pc_write, ir_write, reg_write, mem_read, mem_write,
    //  alu_src_imm, mem_to_reg, illegal, halted}
    localparam logic [11:0] E_IDLE = 12'b000_000000000;
    localparam logic [11:0] E_F    = 12'b110_110100000;
    localparam logic [11:0] E_FW   = 12'b110_000100000;
    localparam logic [11:0] E_D    = 12'b000_000000000;
    localparam logic [11:0] E_DJ   = 12'b000_100000000;
    localparam logic [11:0] E_DI   = 12'b000_000000010;
    localparam logic [11:0] E_XA   = 12'b001_000000000;
    localparam logic [11:0] E_XL   = 12'b010_000000000;
    localparam logic [11:0] E_XS   = 12'b011_000001000;
    localparam logic [11:0] E_XM   = 12'b110_000001000;
    localparam logic [11:0] E_XB1  = 12'b111_100000000;
    localparam logic [11:0] E_XB0  = 12'b111_000000000;
    localparam logic [11:0] E_ML   = 12'b000_000100000;
    localparam logic [11:0] E_MS   = 12'b000_000010000;
    localparam logic [11:0] E_W    = 12'b000_001000000;
    localparam logic [11:0] E_WL   = 12'b000_001000100;
    localparam logic [11:0] E_H    = 12'b000_000000001;

    localparam logic [5:0] OP_ARITH = 6'b000000;
    localparam logic [5:0] OP_LOGIC = 6'b000001;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_LOAD  = 6'b000011;
    localparam logic [5:0] OP_STORE = 6'b000100;
    localparam logic [5:0] OP_BEQ   = 6'b000101;
    localparam logic [5:0] OP_JUMP  = 6'b000110;
    localparam logic [5:0] OP_BAD   = 6'b101010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef struct {
        string             tag;
        logic [11+CNT_W:0] v;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic [2:0]       alu_op;
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src_imm;
    logic             mem_to_reg;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] retired;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_ret;
    int               n_cmp;
    int               n_bad;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .alu_op      (alu_op),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_src_imm (alu_src_imm),
        .mem_to_reg  (mem_to_reg),
        .illegal     (illegal),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, checked mid-cycle
    initial begin
        exp_t             e;
        logic [11+CNT_W:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {alu_op, pc_write, ir_write, reg_write, mem_read,
                       mem_write, alu_src_imm, mem_to_reg, illegal,
                       halted, retired};
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
                end
            end
        end
    end

    task automatic push(input string tag, input logic [11:0] e);
        exp_t x;
        x.tag = tag;
        x.v   = {e, exp_ret};
        sb.push_back(x);
    endtask

    task automatic cyc(input string tag, input logic st,
                       input logic [5:0] op, input logic z,
                       input logic mr, input logic [11:0] e,
                       input bit inc);
        @(posedge clk);
        #1;
        start     = st;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        push(tag, e);
        if (inc) exp_ret = exp_ret + 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_ret   = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        cyc("reset", 0, OP_ARITH, 0, 0, E_IDLE, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        cyc("idle", 0, OP_ARITH, 0, 1, E_IDLE, 0);
        cyc("a_idle", 1, OP_ARITH, 0, 1, E_IDLE, 0);
        cyc("a_f", 1, OP_ARITH, 0, 1, E_F, 0);
        cyc("a_d", 0, OP_ARITH, 0, 1, E_D, 0);
        cyc("a_x", 0, OP_HALT, 0, 1, E_XA, 0);
        cyc("a_w", 0, OP_BAD, 0, 1, E_W, 1);

        cyc("ld_f", 0, OP_LOAD, 0, 1, E_F, 0);
        cyc("ld_d", 0, OP_LOAD, 0, 1, E_D, 0);
        cyc("ld_x", 0, OP_LOAD, 0, 0, E_XM, 0);
        cyc("ld_m0", 0, OP_LOAD, 0, 0, E_ML, 0);
        cyc("ld_m1", 0, OP_LOAD, 0, 0, E_ML, 0);
        cyc("ld_m2", 0, OP_LOAD, 0, 1, E_ML, 0);
        cyc("ld_w", 0, OP_LOAD, 0, 1, E_WL, 1);

        cyc("bq1_f", 0, OP_BEQ, 0, 1, E_F, 0);
        cyc("bq1_d", 0, OP_BEQ, 1, 1, E_D, 0);
        cyc("bq1_x", 0, OP_BEQ, 1, 1, E_XB1, 1);
        cyc("bq0_f", 0, OP_BEQ, 1, 1, E_F, 0);
        cyc("bq0_d", 0, OP_BEQ, 0, 1, E_D, 0);
        cyc("bq0_x", 0, OP_BEQ, 0, 1, E_XB0, 1);

        cyc("lg_fw", 0, OP_LOGIC, 0, 0, E_FW, 0);
        cyc("lg_f", 0, OP_LOGIC, 0, 1, E_F, 0);
        cyc("lg_d", 0, OP_LOGIC, 0, 0, E_D, 0);
        cyc("lg_x", 0, OP_LOGIC, 0, 0, E_XL, 0);
        cyc("lg_w", 0, OP_LOGIC, 0, 0, E_W, 1);

        cyc("sh_f", 0, OP_SHIFT, 0, 1, E_F, 0);
        cyc("sh_d", 0, OP_SHIFT, 0, 1, E_D, 0);
        cyc("sh_x", 0, OP_SHIFT, 0, 1, E_XS, 0);
        cyc("sh_w", 0, OP_SHIFT, 0, 1, E_W, 1);

        cyc("il_f", 0, OP_BAD, 0, 1, E_F, 0);
        cyc("il_d", 0, OP_BAD, 0, 1, E_DI, 0);
        cyc("il_f2", 0, OP_STORE, 0, 1, E_F, 0);

        cyc("st_d", 0, OP_STORE, 0, 1, E_D, 0);
        cyc("st_x", 0, OP_STORE, 0, 1, E_XM, 0);
        cyc("st_m0", 0, OP_STORE, 0, 0, E_MS, 0);

        // Abort in the middle of the STORE stall
        @(posedge clk);
        #1 mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        exp_ret = '0;
        push("rst_abort", E_IDLE);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        cyc("post_idle0", 0, OP_JUMP, 0, 1, E_IDLE, 0);
        cyc("post_idle1", 0, OP_JUMP, 0, 1, E_IDLE, 0);
        cyc("post_start", 1, OP_JUMP, 0, 1, E_IDLE, 0);

        for (int i = 0; i < (1 << CNT_W); i++) begin
            cyc("j_f", 0, OP_JUMP, 0, 1, E_F, 0);
            cyc("j_d", 0, OP_JUMP, 0, 1, E_DJ, 1);
        end

        cyc("st2_f", 0, OP_STORE, 0, 1, E_F, 0);
        cyc("st2_d", 0, OP_STORE, 0, 1, E_D, 0);
        cyc("st2_x", 0, OP_STORE, 0, 1, E_XM, 0);
        cyc("st2_m", 0, OP_STORE, 0, 1, E_MS, 1);

        cyc("h_f", 0, OP_HALT, 0, 1, E_F, 0);
        cyc("h_d", 0, OP_HALT, 0, 1, E_D, 0);
        cyc("h_0", 1, OP_ARITH, 0, 1, E_H, 0);
        cyc("h_1", 1, OP_JUMP, 1, 0, E_H, 0);
        cyc("h_2", 0, OP_LOAD, 0, 1, E_H, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
